// File: rtl/count_monitor_pkg.sv
// Shared definitions for the count_monitor block: FSM state encoding and
// the saturation limit of the error counter.
`ifndef COUNT_MONITOR_PKG_SV
`define COUNT_MONITOR_PKG_SV
package count_monitor_pkg;

  typedef enum logic [1:0] {
    ACQUIRE = 2'd0,
    TRACK   = 2'd1,
    RELOCK  = 2'd2
  } state_t;

  localparam logic [3:0] ERR_MAX = 4'd15;

endpackage
`endif

// File: rtl/count_monitor_sat_counter.sv
// Four-bit event counter that sticks at ERR_MAX instead of wrapping.
module sat_counter
  import count_monitor_pkg::*;
(
  input  logic       clock,
  input  logic       clear,
  input  logic       inc,
  output logic [3:0] q
);

  logic [3:0] r_q;

  always_ff @(posedge clock) begin
    if (clear) begin
      r_q <= 4'd0;
    end else if (inc && (r_q != ERR_MAX)) begin
      r_q <= r_q + 4'd1;
    end
  end

  assign q = r_q;

endmodule

// File: rtl/count_monitor.sv
// Watches a sampled 3-bit up-counter, reports sequence breaks, valid 7->0
// wraps and lock status; every output is registered one cycle after sampling.
module count_monitor
  import count_monitor_pkg::*;
#(
  parameter int WRAP_W   = 8,
  parameter int GOOD_RUN = 3
) (
  input  logic              clock,
  input  logic              clear,
  input  logic [2:0]        count_in,
  input  logic              sample_en,
  output logic              locked,
  output logic              seq_error,
  output logic              wrap_pulse,
  output logic [WRAP_W-1:0] wrap_count,
  output logic [3:0]        error_count,
  output logic [1:0]        dbg_state
);

  localparam int RUN_W = (GOOD_RUN < 2) ? 1 : $clog2(GOOD_RUN + 1);
  localparam logic [RUN_W-1:0] RUN_TARGET = RUN_W'(GOOD_RUN);

  state_t            r_state;
  logic [2:0]        r_prev;
  logic [RUN_W-1:0]  r_run;
  logic              r_locked;
  logic              r_seq_error;
  logic              r_wrap_pulse;
  logic [WRAP_W-1:0] r_wrap_count;

  state_t            w_state_nxt;
  logic [2:0]        w_prev_nxt;
  logic [RUN_W-1:0]  w_run_nxt;
  logic [RUN_W-1:0]  w_run_inc;
  logic              w_locked_nxt;
  logic              w_err_p;
  logic              w_wrap_p;
  logic [2:0]        w_expected;
  logic              w_match;
  logic              w_wrap;

  // A held value never equals prev+1 mod 8, so it falls out as a mismatch.
  assign w_expected = r_prev + 3'd1;
  assign w_match    = (count_in == w_expected);
  assign w_wrap     = (r_prev == 3'd7) && (count_in == 3'd0);
  assign w_run_inc  = r_run + RUN_W'(1);

  always_ff @(posedge clock) begin
    if (clear) begin
      r_state      <= ACQUIRE;
      r_prev       <= 3'd0;
      r_run        <= '0;
      r_locked     <= 1'b0;
      r_seq_error  <= 1'b0;
      r_wrap_pulse <= 1'b0;
      r_wrap_count <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_prev       <= w_prev_nxt;
      r_run        <= w_run_nxt;
      r_locked     <= w_locked_nxt;
      r_seq_error  <= w_err_p;
      r_wrap_pulse <= w_wrap_p;
      if (w_wrap_p) begin
        r_wrap_count <= r_wrap_count + WRAP_W'(1);
      end
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_prev_nxt   = r_prev;
    w_run_nxt    = r_run;
    w_locked_nxt = r_locked;
    w_err_p      = 1'b0;
    w_wrap_p     = 1'b0;
    if (sample_en) begin
      w_prev_nxt = count_in;
      case (r_state)
        ACQUIRE: w_state_nxt = TRACK;
        TRACK: begin
          if (w_match) begin
            w_locked_nxt = 1'b1;
            w_wrap_p     = w_wrap;
          end else begin
            w_err_p      = 1'b1;
            w_run_nxt    = '0;
            w_locked_nxt = 1'b0;
            w_state_nxt  = RELOCK;
          end
        end
        RELOCK: begin
          if (w_match) begin
            w_wrap_p = w_wrap;
            if (w_run_inc == RUN_TARGET) begin
              w_run_nxt    = '0;
              w_locked_nxt = 1'b1;
              w_state_nxt  = TRACK;
            end else begin
              w_run_nxt = w_run_inc;
            end
          end else begin
            w_err_p   = 1'b1;
            w_run_nxt = '0;
          end
        end
        default: w_state_nxt = ACQUIRE;
      endcase
    end
  end

  sat_counter u_err_cnt (
    .clock (clock),
    .clear (clear),
    .inc   (w_err_p),
    .q     (error_count)
  );

  assign locked     = r_locked;
  assign seq_error  = r_seq_error;
  assign wrap_pulse = r_wrap_pulse;
  assign wrap_count = r_wrap_count;
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_count_monitor.sv
// Self-checking bench for count_monitor: directed scenarios plus a randomized
// stream, all compared against a behavioural model of the counting rules.
module tb_count_monitor;

  localparam int WRAP_W   = 8;
  localparam int GOOD_RUN = 3;

  logic              clock;
  logic              clear;
  logic [2:0]        count_in;
  logic              sample_en;
  logic              locked;
  logic              seq_error;
  logic              wrap_pulse;
  logic [WRAP_W-1:0] wrap_count;
  logic [3:0]        error_count;
  logic [1:0]        dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: "synced" = a previous sample exists, "relocking" = a
  // break happened and fewer than GOOD_RUN matches have followed it.
  bit m_synced;
  bit m_relocking;
  bit m_locked;
  bit m_err_p;
  bit m_wrap_p;
  int m_prev;
  int m_run;
  int m_errs;
  int m_wraps;

  count_monitor #(.WRAP_W(WRAP_W), .GOOD_RUN(GOOD_RUN)) dut (
    .clock       (clock),
    .clear       (clear),
    .count_in    (count_in),
    .sample_en   (sample_en),
    .locked      (locked),
    .seq_error   (seq_error),
    .wrap_pulse  (wrap_pulse),
    .wrap_count  (wrap_count),
    .error_count (error_count),
    .dbg_state   (dbg_state)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_synced = 0; m_relocking = 0; m_locked = 0;
    m_err_p = 0; m_wrap_p = 0;
    m_prev = 0; m_run = 0; m_errs = 0; m_wraps = 0;
  endtask

  task automatic model_sample(input int v);
    m_err_p  = 0;
    m_wrap_p = 0;
    if (!m_synced) begin
      m_synced = 1;
    end else if (v == (m_prev + 1) % 8) begin
      if (m_prev == 7) begin
        m_wrap_p = 1;
        m_wraps++;
      end
      if (m_relocking) begin
        m_run++;
        if (m_run == GOOD_RUN) begin
          m_relocking = 0;
          m_run       = 0;
          m_locked    = 1;
        end
      end else begin
        m_locked = 1;
      end
    end else begin
      m_err_p     = 1;
      m_errs      = (m_errs < 15) ? m_errs + 1 : 15;
      m_run       = 0;
      m_relocking = 1;
      m_locked    = 0;
    end
    m_prev = v;
  endtask

  task automatic check_all(input string tag);
    int exp_state;
    exp_state = !m_synced ? 0 : (m_relocking ? 2 : 1);
    check({tag, ".locked"},      32'(locked),      32'(m_locked));
    check({tag, ".seq_error"},   32'(seq_error),   32'(m_err_p));
    check({tag, ".wrap_pulse"},  32'(wrap_pulse),  32'(m_wrap_p));
    check({tag, ".wrap_count"},  32'(wrap_count),  32'(m_wraps % (1 << WRAP_W)));
    check({tag, ".error_count"}, 32'(error_count), 32'(m_errs));
    check({tag, ".state"},       32'(dbg_state),   32'(exp_state));
  endtask

  task automatic do_sample(input int v, input string tag);
    @(negedge clock);
    count_in  = 3'(v);
    sample_en = 1'b1;
    @(posedge clock);
    model_sample(v);
    #1;
    check_all(tag);
  endtask

  task automatic do_idle(input string tag);
    @(negedge clock);
    count_in  = 3'($urandom_range(0, 7));
    sample_en = 1'b0;
    @(posedge clock);
    m_err_p  = 0;
    m_wrap_p = 0;
    #1;
    check_all(tag);
  endtask

  task automatic do_clear(input string tag);
    @(negedge clock);
    clear     = 1'b1;
    sample_en = 1'b1;
    count_in  = 3'($urandom_range(0, 7));
    @(posedge clock);
    model_reset();
    #1;
    check_all(tag);
    @(negedge clock);
    clear     = 1'b0;
    sample_en = 1'b0;
  endtask

  initial begin
    int v;
    clear     = 1'b1;
    sample_en = 1'b0;
    count_in  = 3'd0;
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    check_all("reset");
    do_clear("reset2");

    // Clean 0..7,0 run: one wrap, no errors.
    for (int i = 0; i <= 8; i++) do_sample(i % 8, "seq030");
    check("seq030.wraps_const", 32'(wrap_count), 32'd1);
    check("seq030.errs_const", 32'(error_count), 32'd0);

    // Break on 5, relock over 6,7,0 with a wrap in RELOCK.
    do_sample(1, "seq031"); do_sample(2, "seq031"); do_sample(3, "seq031");
    do_sample(5, "seq031_break");
    check("seq031.errs_const", 32'(error_count), 32'd1);
    do_sample(6, "seq031"); do_sample(7, "seq031");
    do_sample(0, "seq031_relock");
    check("seq031.locked_const", 32'(locked), 32'd1);
    check("seq031.wraps_const", 32'(wrap_count), 32'd2);

    // Good run interrupted at 4, relock only after 5,6,7.
    do_sample(0, "seq032_hold");
    do_sample(1, "seq032"); do_sample(2, "seq032");
    do_sample(4, "seq032_break");
    do_sample(5, "seq032"); do_sample(6, "seq032");
    check("seq032.still_unlocked", 32'(locked), 32'd0);
    do_sample(7, "seq032_relock");
    check("seq032.locked_const", 32'(locked), 32'd1);

    // 20 held samples: every one is a break, count sticks at 15.
    for (int i = 0; i < 20; i++) do_sample(7, "sat033");
    check("sat033.errs_const", 32'(error_count), 32'd15);

    // Three wraps, drop into RELOCK, then clear overrides a sample.
    do_clear("pre034");
    for (int i = 0; i <= 24; i++) do_sample(i % 8, "wrap034");
    do_sample(3, "break034");
    do_sample(4, "run034");
    check("pre034.wraps_const", 32'(wrap_count), 32'd3);
    do_clear("clear034");
    do_sample(7, "first034");
    do_sample(0, "wrap_after034");

    // Stalled cycles interleaved with a valid sequence.
    for (int i = 1; i <= 10; i++) begin
      do_sample(i % 8, "stall035_s");
      do_idle("stall035_i");
    end

    // Randomized stream biased towards correct counting.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) do_idle("rand_i");
      else begin
        v = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 7)) : (m_prev + 1) % 8;
        do_sample(v, "rand_s");
      end
    end

    // Push wrap_count past 2^WRAP_W to see it roll over.
    do_clear("pre_roll");
    for (int i = 0; i <= 8 * 260; i++) begin
      @(negedge clock);
      count_in  = 3'(i % 8);
      sample_en = 1'b1;
      @(posedge clock);
      model_sample(i % 8);
    end
    #1;
    check_all("roll");
    check("roll.wraps_const", 32'(wrap_count), 32'd4);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/count_monitor.md
COUNT_MONITOR -- requirements
Module: count_monitor

Interface
REQ-001 SHALL have parameter WRAP_W, default 8, width of the wrap counter.
REQ-002 SHALL have parameter GOOD_RUN, default 3, number of consecutive correct samples needed to regain lock.
REQ-003 SHALL have port clock  input  1  sole clock; all state changes on its rising edge.
REQ-004 SHALL have port clear  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port count_in  input  3  count value from the upstream 3-bit counter.
REQ-006 SHALL have port sample_en  input  1  count_in is sampled on this edge when high.
REQ-007 SHALL have port locked  output  1  high while the sampled sequence is tracking correctly.
REQ-008 SHALL have port seq_error  output  1  one-cycle pulse on each detected sequence break.
REQ-009 SHALL have port wrap_pulse  output  1  one-cycle pulse on each valid 7->0 transition.
REQ-010 SHALL have port wrap_count  output  WRAP_W  number of valid wraps since reset, modulo 2^WRAP_W.
REQ-011 SHALL have port error_count  output  4  sequence breaks since reset, saturating at 15.

Function
REQ-012 SHALL implement FSM states ACQUIRE, TRACK, RELOCK; all outputs registered; response appears the cycle after the sampling edge.
REQ-013 ACQUIRE: on sample_en, SHALL store count_in as prev and go to TRACK; no pulses, no counter updates.
REQ-014 TRACK/RELOCK: on sample_en, expected = (prev + 1) mod 8; prev SHALL always update to count_in.
REQ-015 TRACK, count_in == expected: SHALL stay in TRACK, locked = 1.
REQ-016 TRACK, count_in != expected: SHALL pulse seq_error, increment error_count (saturate at 15), clear the good-run count, go to RELOCK, locked = 0.
REQ-017 RELOCK, match: SHALL increment the good-run count; when it reaches GOOD_RUN, SHALL go to TRACK and set locked = 1.
REQ-018 RELOCK, mismatch: SHALL pulse seq_error, increment error_count (saturating), reset the good-run count to 0, and stay in RELOCK.
REQ-019 wrap_pulse and wrap_count increment SHALL occur only when prev == 7, count_in == 0, and the sample is a match, in TRACK or RELOCK.
REQ-020 wrap_count SHALL roll over from 2^WRAP_W-1 to 0 without a flag.
REQ-021 With sample_en low, all state SHALL hold and pulse outputs SHALL be 0.
REQ-022 Hold-value samples (count_in == prev) SHALL be treated as mismatches.

Reset
REQ-023 With clear high at a rising edge, the block SHALL enter ACQUIRE.
REQ-024 On that reset, locked, seq_error, wrap_pulse, wrap_count, error_count, prev, and the good-run count SHALL all be 0.
REQ-025 clear SHALL override sample_en in the same cycle.
REQ-026 A clear mid-RELOCK SHALL discard the partial good-run count.

Structure
REQ-027 State encodings (ACQUIRE=0, TRACK=1, RELOCK=2) and the constant ERR_MAX=15 SHALL reside in a shared package/include file guarded against double inclusion.
REQ-028 The saturating error counter SHALL be one sub-module, sat_counter, with ports clock, clear, inc, and a 4-bit q.
REQ-029 No other sub-modules SHALL be used; the 3-bit increment compare SHALL be done inline.

Verification
REQ-030 Reset, then feed 0,1,...,7,0 with sample_en=1: locked=1 from the second sample onward, wrap_pulse exactly once on the 7->0 sample, wrap_count=1, error_count=0.
REQ-031 While locked, feed 2,3,5: one seq_error pulse on 5, locked=0, error_count=1; then 6,7,0: locked=1 after the third match, wrap_count incremented on 0.
REQ-032 In RELOCK, feed 1,2,4 then 5,6,7: good-run restarts at 4; locked re-asserts only after 7.
REQ-033 Inject 20 mismatches: error_count stops at 15; seq_error pulses on all 20.
REQ-034 Assert clear during RELOCK with wrap_count=3: next cycle all outputs 0, state ACQUIRE; the first sample after reset produces no pulse.
REQ-035 With sample_en toggling every other cycle over a valid sequence: no errors; stalled cycles show pulse outputs 0 and held state.
